// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/memory/writeback sequencer for the 8-bit accumulator CPU.
// Optional single-step mode: define CPU_SEQ_STEP_EN.
module cpu_seq #(
  parameter int unsigned PC_W      = 5,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [7:0]  HALT_INST = 8'h0F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      inst_i,
  output logic [7:0]      inst_o,
  input  logic            dec_rmem,
  input  logic            dec_wmem,
  input  logic            dec_wresreg,
  input  logic            dec_wpc,
  input  logic [PC_W-1:0] dec_pc,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            resreg_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  // Last waiting cycle index; an ack arriving in that cycle still completes.
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t     state, next;
  logic [3:0] cnt;
  logic       go;

`ifdef CPU_SEQ_STEP_EN
  logic run_q;

  always_ff @(posedge clk) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= run;
  end

  assign go = run & ~run_q;
`else
  assign go = run;
`endif

  assign imem_addr = pc;

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (go) next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)             next = S_DECODE;
        else if (cnt == TMO_LAST) next = S_ERR;
      end
      S_DECODE: begin
        if (inst_o == HALT_INST)       next = S_HALT;
        else if (dec_rmem || dec_wmem) next = S_MEM;
        else                           next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)             next = S_WB;
        else if (cnt == TMO_LAST) next = S_ERR;
      end
      S_WB: begin
`ifdef CPU_SEQ_STEP_EN
        next = S_IDLE;
`else
        next = run ? S_FETCH : S_IDLE;
`endif
      end
      S_HALT:   next = S_HALT;
      S_ERR:    next = S_ERR;
      default:  next = S_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      inst_o    <= '0;
      cnt       <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      resreg_we <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= next;
      if (state == S_FETCH && imem_ack) inst_o <= inst_i;
      if (state == S_WB) pc <= dec_wpc ? dec_pc : pc + PC_W'(1);
      if (next != state)                          cnt <= '0;
      else if (state == S_FETCH || state == S_MEM) cnt <= cnt + 4'd1;
      imem_req  <= (next == S_FETCH);
      dmem_req  <= (next == S_MEM);
      dmem_we   <= (next == S_MEM) && dec_wmem;
      resreg_we <= (next == S_WB) && dec_wresreg;
      busy      <= (next == S_FETCH) || (next == S_DECODE) ||
                   (next == S_MEM)   || (next == S_WB);
      halted    <= (next == S_HALT);
      err       <= (next == S_ERR);
    end
  end

endmodule
